hilo_ctrl: RTL



---
 rtl/hilo_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hilo_ctrl.sv
// HI/LO control stage between the CPU control unit and the sequential Booth multiplier.
// Optional RUN-state watchdog is enabled by defining HILO_WDOG_EN.
module hilo_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 48
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_rs_val,
    input  logic [WIDTH-1:0] i_rt_val,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd_hilo,
    input  logic             i_mult_done,
    input  logic [WIDTH-1:0] i_mult_hi,
    input  logic [WIDTH-1:0] i_mult_lo,
    output logic             o_mult_init,
    output logic [WIDTH-1:0] o_mult_a,
    output logic [WIDTH-1:0] o_mult_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_timeout;
    logic             w_active_next;
    logic             r_active;
    logic [WIDTH-1:0] r_mult_a;
    logic [WIDTH-1:0] r_mult_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

`ifdef HILO_WDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // A late mult_done in the final RUN cycle still wins over the watchdog.
    assign w_timeout = (r_state == ST_RUN) && !i_mult_done &&
                       (r_cnt == CNT_W'(TIMEOUT - 1));

    // RUN-cycle counter, cleared on every launch.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == ST_LAUNCH) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Sticky watchdog error flag.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    // Next-state logic; mult_done is deliberately not looked at in LAUNCH.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = ST_LAUNCH;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LAUNCH:  w_next = ST_RUN;
            ST_RUN: begin
                if (i_mult_done) begin
                    w_next = ST_CAPTURE;
                end else if (w_timeout) begin
                    w_next = ST_DRAIN;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_CAPTURE: w_next = ST_DRAIN;
            ST_DRAIN:   w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    assign w_active_next = (w_next == ST_LAUNCH) || (w_next == ST_RUN) ||
                           (w_next == ST_CAPTURE);

    // State register plus registered multiplier-start / busy level.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_active <= w_active_next;
        end
    end

    // Operand latching and HI/LO updates; moves to HI/LO only land when idle and not starting.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_mult_a <= {WIDTH{1'b0}};
            r_mult_b <= {WIDTH{1'b0}};
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mult_a <= i_rs_val;
                        r_mult_b <= i_rt_val;
                    end else begin
                        if (i_mthi) begin
                            r_hi <= i_wdata;
                        end
                        if (i_mtlo) begin
                            r_lo <= i_wdata;
                        end
                    end
                end
                ST_CAPTURE: begin
                    r_hi <= i_mult_hi;
                    r_lo <= i_mult_lo;
                end
                default: begin
                    r_hi <= r_hi;
                    r_lo <= r_lo;
                end
            endcase
        end
    end

    assign o_mult_init = r_active;
    assign o_busy      = r_active;
    assign o_mult_a    = r_mult_a;
    assign o_mult_b    = r_mult_b;
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;
    assign o_stall     = r_active & (i_start | i_rd_hilo | i_mthi | i_mtlo);

endmodule
